// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg : shared constants, state encoding and helpers for the multipliers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam int MULT_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_if.sv
// ---------------------------------------------------------------------------
// seq_mult_if : operand/result handshake bundle for the sequential multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_mult_if #(
  parameter int N = mult_pkg::MULT_N_DEFAULT
) ();

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   op1;
  logic [N-1:0]   op2;
  logic           op1_signed;
  logic           op2_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out;

  modport master (
    output in_valid, op1, op2, op1_signed, op2_signed, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, op1, op2, op1_signed, op2_signed, out_ready,
    output in_ready, out_valid, out
  );

endinterface

`default_nettype wire

// File: rtl/cond_negate.sv
// ---------------------------------------------------------------------------
// cond_negate : combinational two's-complement negate when neg_i is set
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cond_negate #(
  parameter int W = 8
) (
  input  logic         neg_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult : N-cycle shift-add multiplier with per-operand signed/unsigned mode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mult
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_mult_if.slave bus
);

  localparam int            CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q;
  logic [2*N-1:0]   mcand_q;
  logic [N-1:0]     mplier_q;
  logic             sign_q;
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   out_q;
  logic [CW-1:0]    cnt_q;

  logic             neg1_d;
  logic             neg2_d;
  logic [N-1:0]     mag1_d;
  logic [N-1:0]     mag2_d;
  logic [2*N-1:0]   acc_d;
  logic [2*N-1:0]   prod_d;

  assign neg1_d = bus.op1_signed & bus.op1[N-1];
  assign neg2_d = bus.op2_signed & bus.op2[N-1];

  cond_negate #(.W(N)) u_neg_op1 (
    .neg_i (neg1_d),
    .in_i  (bus.op1),
    .out_o (mag1_d)
  );

  cond_negate #(.W(N)) u_neg_op2 (
    .neg_i (neg2_d),
    .in_i  (bus.op2),
    .out_o (mag2_d)
  );

  // Shift-register form: multiplicand walks left, multiplier bits drain from bit 0.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Sign fix-up is applied to the final partial sum so DONE needs no extra cycle.
  cond_negate #(.W(2*N)) u_neg_res (
    .neg_i (sign_q),
    .in_i  (acc_d),
    .out_o (prod_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            mcand_q  <= {{N{1'b0}}, mag1_d};
            mplier_q <= mag2_d;
            sign_q   <= neg1_d ^ neg2_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_q   <= prod_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_mult : scoreboard bench for seq_mult at N=3, N=4 and N=8
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_mult;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit done8  = 1'b0;

  localparam int NW [3] = '{3, 4, 8};

  logic [7:0]  d_op1 [3];
  logic [7:0]  d_op2 [3];
  logic        d_s1 [3];
  logic        d_s2 [3];
  logic        d_valid [3];
  logic        d_ordy [3];
  logic [15:0] w_out [3];
  logic        w_rdy [3];
  logic        w_ov [3];

  seq_mult_if #(.N(3)) if3 ();
  seq_mult_if #(.N(4)) if4 ();
  seq_mult_if #(.N(8)) if8 ();

  assign if3.in_valid = d_valid[0];
  assign if3.op1 = d_op1[0][2:0];
  assign if3.op2 = d_op2[0][2:0];
  assign if3.op1_signed = d_s1[0];
  assign if3.op2_signed = d_s2[0];
  assign if3.out_ready = d_ordy[0];
  assign w_out[0] = {10'b0, if3.out};
  assign w_rdy[0] = if3.in_ready;
  assign w_ov[0]  = if3.out_valid;

  assign if4.in_valid = d_valid[1];
  assign if4.op1 = d_op1[1][3:0];
  assign if4.op2 = d_op2[1][3:0];
  assign if4.op1_signed = d_s1[1];
  assign if4.op2_signed = d_s2[1];
  assign if4.out_ready = d_ordy[1];
  assign w_out[1] = {8'b0, if4.out};
  assign w_rdy[1] = if4.in_ready;
  assign w_ov[1]  = if4.out_valid;

  assign if8.in_valid = d_valid[2];
  assign if8.op1 = d_op1[2];
  assign if8.op2 = d_op2[2];
  assign if8.op1_signed = d_s1[2];
  assign if8.op2_signed = d_s2[2];
  assign if8.out_ready = d_ordy[2];
  assign w_out[2] = if8.out;
  assign w_rdy[2] = if8.in_ready;
  assign w_ov[2]  = if8.out_valid;

  seq_mult #(.N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  seq_mult #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  seq_mult #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  typedef struct {
    int          id;
    logic [15:0] exp;
    int          acc_edge;
  } ent_t;

  ent_t sb [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int find(input int id);
    foreach (sb[k]) if (sb[k].id == id) return k;
    return -1;
  endfunction

  // Reference: interpret each operand as an integer, multiply, keep 2N bits.
  function automatic logic [15:0] ref_prod(input int n, input logic [7:0] a, input logic [7:0] b,
                                           input bit s1, input bit s2);
    longint va, vb, p, m;
    m  = (longint'(1) << n) - 1;
    va = longint'(a) & m;
    vb = longint'(b) & m;
    if (s1 && a[n-1]) va = va - (longint'(1) << n);
    if (s2 && b[n-1]) vb = vb - (longint'(1) << n);
    p = va * vb;
    return 16'(p & ((longint'(1) << (2 * n)) - 1));
  endfunction

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                       input bit s1, input bit s2);
    int t;
    @(posedge clk); #1;
    d_op1[i] = a; d_op2[i] = b; d_s1[i] = s1; d_s2[i] = s2; d_valid[i] = 1'b1;
    t = 0;
    while (!w_rdy[i] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!w_rdy[i]) begin
      chk($sformatf("accept_timeout%0d", i), t, 0);
      d_valid[i] = 1'b0;
      return;
    end
    sb.push_back('{id: i, exp: ref_prod(NW[i], a, b, s1, s2), acc_edge: cyc + 1});
    @(posedge clk); #1;
    d_valid[i] = 1'b0;
  endtask

  task automatic wait_drained(input int i);
    int t;
    t = 0;
    while ((find(i) >= 0 || !w_rdy[i]) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("drain_wait%0d", i), longint'(find(i) < 0), 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  bit          seen [3];
  bit          post_hs [3];
  logic [15:0] hold [3];

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        int k;
        if (post_hs[i]) begin
          chk($sformatf("next_accept%0d", i), w_rdy[i], 1);
          post_hs[i] = 1'b0;
        end
        if (w_ov[i]) begin
          k = find(i);
          if (!seen[i]) begin
            seen[i] = 1'b1;
            hold[i] = w_out[i];
            chk($sformatf("pending_entry%0d", i), longint'(k >= 0), 1);
            if (k >= 0) chk($sformatf("latency%0d", i), cyc - sb[k].acc_edge, NW[i]);
          end else begin
            chk($sformatf("stable_out%0d", i), w_out[i], hold[i]);
            chk($sformatf("in_ready_done%0d", i), w_rdy[i], 0);
          end
          if (d_ordy[i]) begin
            if (k >= 0) begin
              chk($sformatf("product%0d", i), w_out[i], sb[k].exp);
              sb.delete(k);
            end
            seen[i]    = 1'b0;
            post_hs[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      d_op1[i] = '0; d_op2[i] = '0; d_s1[i] = 1'b0; d_s2[i] = 1'b0;
      d_valid[i] = 1'b0; d_ordy[i] = 1'b1;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), w_rdy[i], 1);
      chk($sformatf("rst_out_valid%0d", i), w_ov[i], 0);
      chk($sformatf("rst_out%0d", i), w_out[i], 0);
    end
    rst_n = 1'b1;

    issue(1, 8'h08, 8'h08, 1'b1, 1'b1);
    issue(1, 8'h0F, 8'h0F, 1'b0, 1'b0);
    issue(1, 8'h08, 8'h0F, 1'b1, 1'b0);
    issue(2, 8'hFD, 8'h00, 1'b1, 1'b1);
    issue(2, 8'h7F, 8'h80, 1'b1, 1'b1);

    // Back-pressure with upstream noise on the inputs while busy and done.
    wait_drained(2);
    d_ordy[2] = 1'b0;
    issue(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    repeat (NW[2] + 5) begin
      @(posedge clk); #1;
      d_op1[2] = 8'($urandom); d_op2[2] = 8'($urandom);
      d_s1[2] = 1'($urandom); d_s2[2] = 1'($urandom);
      d_valid[2] = 1'($urandom);
    end
    d_valid[2] = 1'b0;
    d_ordy[2]  = 1'b1;
    issue(2, 8'h03, 8'h05, 1'b0, 1'b0);

    // Reset during BUSY cycle 2 discards the operation.
    wait_drained(2);
    issue(2, 8'h55, 8'h33, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", w_rdy[2], 1);
    chk("midrst_out_valid", w_ov[2], 0);
    chk("midrst_out", w_out[2], 0);
    while (find(2) >= 0) sb.delete(find(2));
    seen[2]    = 1'b0;
    post_hs[2] = 1'b0;
    rst_n = 1'b1;
    issue(2, 8'h05, 8'hFA, 1'b1, 1'b1);
    wait_drained(2);

    fork
      begin
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 8; b++)
            for (int m = 0; m < 4; m++)
              issue(0, 8'(a), 8'(b), m[1], m[0]);
      end
      begin
        repeat (150) issue(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        done8 = 1'b1;
      end
      begin
        while (!done8) begin
          @(posedge clk); #1;
          d_ordy[2] = ($urandom_range(0, 3) != 0);
        end
        d_ordy[2] = 1'b1;
      end
      begin
        repeat (40) issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
    join

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
